// File: rtl/rst_domain_sequencer.sv
// rtl/rst_domain_sequencer.sv - serialised clock-enable / reset-release sequencer for NUM_DOM domains
// One shared FSM and down-counter walk each domain up (clock, release, settle) or down (reset, gate).
module rst_domain_sequencer #(
  parameter int NUM_DOM  = 4,
  parameter int CLK_LEAD = 5,
  parameter int SETTLE   = 6,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DOM-1:0] dom_rst_req_i,
  output logic [NUM_DOM-1:0] clk_en_o,
  output logic [NUM_DOM-1:0] rst_release_o,
  output logic [NUM_DOM-1:0] ready_o,
  output logic               busy_o,
  output logic               seq_done_o
);

  localparam int               IDX_W       = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] LEAD_LOAD   = CNT_W'(CLK_LEAD - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    UP_CLK,
    UP_SETTLE,
    DN_RST
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] clk_en_q, clk_en_d;
  logic [NUM_DOM-1:0] rel_q, rel_d;
  logic [NUM_DOM-1:0] rdy_q, rdy_d;

  logic [NUM_DOM-1:0] up_pend, dn_pend;
  logic               up_any, dn_any;
  logic [IDX_W-1:0]   up_idx, dn_idx;

  // Lowest-index pending domain in each class; scanning downward lets the lowest index win.
  always_comb begin
    up_pend = ~dom_rst_req_i & ~rdy_q;
    dn_pend = dom_rst_req_i & rel_q;
    up_any  = |up_pend;
    dn_any  = |dn_pend;
    up_idx  = '0;
    dn_idx  = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (up_pend[i]) up_idx = IDX_W'(i);
      if (dn_pend[i]) dn_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    clk_en_d = clk_en_q;
    rel_d    = rel_q;
    rdy_d    = rdy_q;
    case (state_q)
      IDLE: begin
        // Taking a domain down has priority so a held domain is never left running.
        if (dn_any) begin
          idx_d         = dn_idx;
          rel_d[dn_idx] = 1'b0;
          rdy_d[dn_idx] = 1'b0;
          cnt_d         = LEAD_LOAD;
          state_d       = DN_RST;
        end else if (up_any) begin
          idx_d            = up_idx;
          clk_en_d[up_idx] = 1'b1;
          cnt_d            = LEAD_LOAD;
          state_d          = UP_CLK;
        end
      end
      UP_CLK: begin
        if (cnt_q == '0) begin
          rel_d[idx_q] = 1'b1;
          cnt_d        = SETTLE_LOAD;
          state_d      = UP_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      UP_SETTLE: begin
        if (cnt_q == '0) begin
          rdy_d[idx_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DN_RST: begin
        if (cnt_q == '0) begin
          clk_en_d[idx_q] = 1'b0;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      clk_en_q <= '0;
      rel_q    <= '0;
      rdy_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      clk_en_q <= clk_en_d;
      rel_q    <= rel_d;
      rdy_q    <= rdy_d;
    end
  end

  assign clk_en_o      = clk_en_q;
  assign rst_release_o = rel_q;
  assign ready_o       = rdy_q;
  assign busy_o        = (state_q != IDLE);
  assign seq_done_o    = (state_q == IDLE) && (rdy_q == ~dom_rst_req_i);

endmodule

// File: tb/tb_rst_domain_sequencer.sv
// tb/tb_rst_domain_sequencer.sv - vector table and scoreboard bench for rst_domain_sequencer
module tb_rst_domain_sequencer;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] clk_en, rel, rdy;
  logic       busy, done;
  int         edge_n;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    logic [3:0] ce;
    logic [3:0] rl;
    logic [3:0] rd;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    bit         do_rst;
    int         at;
    logic [3:0] req;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  rst_domain_sequencer #(
    .NUM_DOM (4),
    .CLK_LEAD(5),
    .SETTLE  (6),
    .CNT_W   (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dom_rst_req_i(req),
    .clk_en_o     (clk_en),
    .rst_release_o(rel),
    .ready_o      (rdy),
    .busy_o       (busy),
    .seq_done_o   (done)
  );

  always #5 clk = ~clk;

  // Edge 1 is the first rising edge with reset low.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  function automatic exp_t mke(input logic [3:0] ce, input logic [3:0] rl, input logic [3:0] rd,
                               input logic b, input logic d);
    exp_t e;
    e.ce = ce; e.rl = rl; e.rd = rd; e.busy = b; e.done = d;
    return e;
  endfunction

  function automatic vec_t mk(input bit r, input int at, input logic [3:0] rq,
                              input logic [3:0] ce, input logic [3:0] rl, input logic [3:0] rd,
                              input logic b, input logic d);
    vec_t v;
    v.do_rst = r; v.at = at; v.req = rq;
    v.e = mke(ce, rl, rd, b, d);
    return v;
  endfunction

  task automatic check_inv();
    logic [3:0] tr;
    tr = clk_en ^ rdy;
    n_cmp++;
    if (((rel & ~clk_en) !== 4'b0000) || ((rdy & ~rel) !== 4'b0000) ||
        ($countones(tr) > 1) || (busy !== (|tr))) begin
      n_bad++;
      $display("FAIL invariant edge %0d: clk_en=%b rel=%b rdy=%b busy=%b; required rel within clk_en, rdy within rel, <=1 domain in transition, busy=%b",
               edge_n, clk_en, rel, rdy, busy, |tr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_inv();
  endtask

  task automatic advance_to(input int n);
    int g;
    g = 0;
    while (edge_n < n && g < 500) begin
      step();
      g++;
    end
    n_cmp++;
    if (edge_n != n) begin
      n_bad++;
      $display("FAIL advance: reached edge %0d, required edge %0d", edge_n, n);
    end
  endtask

  task automatic check_out(input string nm);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      if ({clk_en, rel, rdy, busy, done} !== {e.ce, e.rl, e.rd, e.busy, e.done}) begin
        n_bad++;
        $display("FAIL %s edge %0d: got clk_en=%b rel=%b rdy=%b busy=%b done=%b, expected clk_en=%b rel=%b rdy=%b busy=%b done=%b",
                 nm, edge_n, clk_en, rel, rdy, busy, done, e.ce, e.rl, e.rd, e.busy, e.done);
      end
    end
  endtask

  initial begin
    // Power-on all up, then domain 2 down and back up.
    vecs.push_back(mk(1,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0,  1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0,  5, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0,  6, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 11, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 12, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 13, 4'b0000, 4'b0011, 4'b0001, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 18, 4'b0000, 4'b0011, 4'b0011, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 24, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 0, 0));
    vecs.push_back(mk(0, 47, 4'b0000, 4'b1111, 4'b1111, 4'b0111, 1, 0));
    vecs.push_back(mk(0, 48, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 0, 1));
    vecs.push_back(mk(0, 60, 4'b0100, 4'b1111, 4'b1111, 4'b1111, 0, 1));
    vecs.push_back(mk(0, 61, 4'b0100, 4'b1111, 4'b1011, 4'b1011, 1, 0));
    vecs.push_back(mk(0, 65, 4'b0100, 4'b1111, 4'b1011, 4'b1011, 1, 0));
    vecs.push_back(mk(0, 66, 4'b0100, 4'b1011, 4'b1011, 4'b1011, 0, 1));
    vecs.push_back(mk(0, 70, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 0, 1));
    vecs.push_back(mk(0, 71, 4'b0000, 4'b1111, 4'b1011, 4'b1011, 1, 0));
    vecs.push_back(mk(0, 76, 4'b0000, 4'b1111, 4'b1111, 4'b1011, 1, 0));
    vecs.push_back(mk(0, 81, 4'b0000, 4'b1111, 4'b1111, 4'b1011, 1, 0));
    vecs.push_back(mk(0, 82, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 0, 1));
    // Power-on with domains 0 and 2 held.
    vecs.push_back(mk(1,  0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0,  1, 4'b0101, 4'b0010, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 12, 4'b0101, 4'b0010, 4'b0010, 4'b0010, 0, 0));
    vecs.push_back(mk(0, 13, 4'b0101, 4'b1010, 4'b0010, 4'b0010, 1, 0));
    vecs.push_back(mk(0, 24, 4'b0101, 4'b1010, 4'b1010, 4'b1010, 0, 1));
    vecs.push_back(mk(0, 30, 4'b0101, 4'b1010, 4'b1010, 4'b1010, 0, 1));
    // Down-pending and up-pending both appear during domain 1 coming up.
    vecs.push_back(mk(1,  0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0,  1, 4'b0011, 4'b0100, 4'b0000, 4'b0000, 1, 0));
    vecs.push_back(mk(0, 24, 4'b0011, 4'b1100, 4'b1100, 4'b1100, 0, 1));
    vecs.push_back(mk(0, 30, 4'b0001, 4'b1100, 4'b1100, 4'b1100, 0, 1));
    vecs.push_back(mk(0, 31, 4'b0001, 4'b1110, 4'b1100, 4'b1100, 1, 0));
    vecs.push_back(mk(0, 33, 4'b1000, 4'b1110, 4'b1100, 4'b1100, 1, 0));
    vecs.push_back(mk(0, 36, 4'b1000, 4'b1110, 4'b1110, 4'b1100, 1, 0));
    vecs.push_back(mk(0, 42, 4'b1000, 4'b1110, 4'b1110, 4'b1110, 0, 0));
    vecs.push_back(mk(0, 43, 4'b1000, 4'b1110, 4'b0110, 4'b0110, 1, 0));
    vecs.push_back(mk(0, 47, 4'b1000, 4'b1110, 4'b0110, 4'b0110, 1, 0));
    vecs.push_back(mk(0, 48, 4'b1000, 4'b0110, 4'b0110, 4'b0110, 0, 0));
    vecs.push_back(mk(0, 49, 4'b1000, 4'b0111, 4'b0110, 4'b0110, 1, 0));
    vecs.push_back(mk(0, 54, 4'b1000, 4'b0111, 4'b0111, 4'b0110, 1, 0));
    vecs.push_back(mk(0, 60, 4'b1000, 4'b0111, 4'b0111, 4'b0111, 0, 1));
    // req[1] raised while domain 1 is settling.
    vecs.push_back(mk(1,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 20, 4'b0010, 4'b0011, 4'b0011, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 24, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 0, 0));
    vecs.push_back(mk(0, 25, 4'b0010, 4'b0011, 4'b0001, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 30, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 31, 4'b0010, 4'b0101, 4'b0001, 4'b0001, 1, 0));
    vecs.push_back(mk(0, 54, 4'b0010, 4'b1101, 4'b1101, 4'b1101, 0, 1));
    // Run into domain 2 UP_CLK ahead of the mid-sequence reset.
    vecs.push_back(mk(1,  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk(0, 27, 4'b0000, 4'b0111, 4'b0011, 4'b0011, 1, 0));

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) begin
        @(negedge clk);
        req   = vecs[i].req;
        reset = 1'b1;
        sb_q.push_back(vecs[i].e);
        #1;
        check_out($sformatf("vec%0d_reset", i));
        @(negedge clk);
        reset = 1'b0;
      end else begin
        advance_to(vecs[i].at);
        sb_q.push_back(vecs[i].e);
        check_out($sformatf("vec%0d_edge%0d", i, vecs[i].at));
        req = vecs[i].req;
      end
    end

    // Asynchronous reset between clock edges, then restart from domain 0.
    #1;
    reset = 1'b1;
    sb_q.push_back(mke(4'b0000, 4'b0000, 4'b0000, 0, 0));
    #1;
    check_out("async_reset_no_edge");
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(mke(4'b0001, 4'b0000, 4'b0000, 1, 0));
    advance_to(1);
    check_out("restart_edge1");
    sb_q.push_back(mke(4'b0001, 4'b0001, 4'b0000, 1, 0));
    advance_to(6);
    check_out("restart_edge6");
    sb_q.push_back(mke(4'b0001, 4'b0001, 4'b0001, 0, 0));
    advance_to(12);
    check_out("restart_edge12");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_domain_sequencer.md
# rst_domain_sequencer

Sequences power-on and on-demand reset of up to NUM_DOM clock/reset domains. Each domain is brought up as clock-enable first, then reset release, then a settle window before it is declared ready. Each domain is taken down as reset first, then clock gate. The block sits next to the top-level reset synchronizer and drives the per-domain clock-gate enables and reset-release lines. One shared counter and FSM serialise all domain transitions, so only one domain is ever in transition.

## Interface
Parameters:
- NUM_DOM, 4: number of managed domains (1..16)
- CLK_LEAD, 5: cycles of running clock before reset release, and cycles of reset before clock gate (≥1)
- SETTLE, 6: cycles after reset release before the domain is ready (≥1)
- CNT_W, 5: counter width; must hold max(CLK_LEAD, SETTLE)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- dom_rst_req_i  in  NUM_DOM  level; bit high = hold domain in reset/gated, low = domain wanted up
- clk_en_o  out  NUM_DOM  per-domain clock-gate enable
- rst_release_o  out  NUM_DOM  per-domain reset release (1 = out of reset)
- ready_o  out  NUM_DOM  domain fully up and settled
- busy_o  out  1  FSM not in IDLE
- seq_done_o  out  1  IDLE and ready_o == ~dom_rst_req_i for all bits

## Operation
- States: IDLE, UP_CLK, UP_SETTLE, DN_RST.
  - Registers: 1 shared down-counter (CNT_W bits), current-domain index, and per-domain clk_en/rst_release/ready registers.
  - All outputs come from registers, except busy_o and seq_done_o, which are decoded from registered state.
- Pending work for domain d:
  - up-pending: req[d]=0 and ready[d]=0.
  - down-pending: req[d]=1 and rst_release[d]=1.
- Selection in IDLE:
  - Any down-pending domain wins over any up-pending domain.
  - Within a class, the lowest index wins.
  - With no pending work, the FSM stays in IDLE.
- IDLE to UP_CLK on domain d: set clk_en[d], load counter with CLK_LEAD-1.
- UP_CLK: decrement. At 0, set rst_release[d], load counter with SETTLE-1, go to UP_SETTLE.
- UP_SETTLE: decrement. At 0, set ready[d], go to IDLE.
- IDLE to DN_RST on domain d: clear rst_release[d] and ready[d], load counter with CLK_LEAD-1.
- DN_RST: decrement. At 0, clear clk_en[d], go to IDLE.
- Sequences are non-preemptive.
  - A change of req[d] during d's own sequence is ignored until IDLE re-evaluates it.
  - A domain that finishes coming up while its req is already high is taken down on the next selection.
- Requests on other domains are queued implicitly by level and served after the current sequence.

## Timing
- Reset:
  - On reset assertion, all outputs go 0 immediately (async), the FSM goes to IDLE and the counter goes to 0.
  - Reset mid-sequence aborts the sequence; no partial state survives.
- Edge numbering: edge 1 is the first rising edge with reset low, and is a selection edge.
- Domain d selected for up at edge E:
  - clk_en_o[d]=1 after E
  - rst_release_o[d]=1 after E+CLK_LEAD
  - ready_o[d]=1 after E+CLK_LEAD+SETTLE; FSM is in IDLE at that same edge
  - next selection at E+CLK_LEAD+SETTLE+1
- Domain d selected for down at edge E:
  - rst_release_o[d]=0 and ready_o[d]=0 after E
  - clk_en_o[d]=0 after E+CLK_LEAD
  - next selection at E+CLK_LEAD+1
- Power-on with defaults and all req low:
  - domain k: clk_en at edge 12k+1, release at 12k+6, ready at 12k+12
  - seq_done_o=1 after edge 48
- busy_o is high from the selection edge through the completing edge.
- Invariants: rst_release_o[d] never 1 while clk_en_o[d]=0; ready_o[d] implies rst_release_o[d].

## Test plan
- Power-on, req=0000, defaults:
  - clk_en_o[0] rises edge 1, rst_release_o[0] edge 6, ready_o[0] edge 12
  - ready_o[3] edge 48; seq_done_o=1 after edge 48
  - at most one domain in transition at any time
- Power-on, req=0101: only domains 1 and 3 come up; ready_o[1] edge 12, ready_o[3] edge 24; domains 0 and 2 stay all-zero.
- All up, then req[2] raised at edge 60:
  - rst_release_o[2] and ready_o[2] fall edge 61, clk_en_o[2] falls edge 66
  - req[2] lowered later: re-up takes 11 edges from selection
- Simultaneous events during domain 1 up-sequence:
  - setup: req[3] rises (down-pending, domain 3 up) and req[0] falls (up-pending)
  - after domain 1 ready, domain 3 down is served first, then domain 0 up
- Toggle during own sequence: req[1] rises during domain 1 UP_SETTLE; domain 1 completes to ready, then is taken down starting the next edge.
- Reset mid-sequence: assert reset during domain 2 UP_CLK; all outputs 0 without a clock edge; after release, the sequence restarts from domain 0 at edge 1.
